// File: rtl/can_fd_bit_destuff_if.sv
// Signal bundle between bit timing / BSP FSM and the CAN FD bit de-stuffer.
interface can_fd_bit_destuff_if;
  logic       sample_point;
  logic       sampled_bit;
  logic       initialize;
  logic       fixed_stuff_mode;
  logic       rx_bit;
  logic       rx_bit_valid;
  logic       stuff_bit_dropped;
  logic       stuff_err;
  logic [2:0] stuff_count_gray;
  logic       stuff_count_parity;

  modport master (
    output sample_point, sampled_bit, initialize, fixed_stuff_mode,
    input  rx_bit, rx_bit_valid, stuff_bit_dropped, stuff_err,
           stuff_count_gray, stuff_count_parity
  );

  modport slave (
    input  sample_point, sampled_bit, initialize, fixed_stuff_mode,
    output rx_bit, rx_bit_valid, stuff_bit_dropped, stuff_err,
           stuff_count_gray, stuff_count_parity
  );
endinterface

// File: rtl/can_fd_bit_destuff.sv
// CAN FD receive de-stuffer: removes dynamic stuff bits in the arbitration/data
// phase and fixed stuff bits in the FD stuff-count/CRC fields, flagging violations.
module can_fd_bit_destuff #(
  parameter int Tp             = 1,
  parameter int STUFF_LEN      = 5,
  parameter int FIXED_INTERVAL = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  can_fd_bit_destuff_if.slave  bus
);

  localparam int RUN_W = $clog2(STUFF_LEN + 1);
  localparam int FIX_W = $clog2(FIXED_INTERVAL + 1);

  // Tp only exists for compatibility with delay-annotated models; no delay is modelled here.
  if (Tp < 0 || STUFF_LEN < 2 || FIXED_INTERVAL < 1) begin : g_param_check
    $error("can_fd_bit_destuff: illegal parameter value");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DYNAMIC = 2'd1,
    FIXED   = 2'd2,
    ERROR   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             rx_bit_q, rx_bit_d;
  logic             rx_bit_valid_q, rx_bit_valid_d;
  logic             stuff_bit_dropped_q, stuff_bit_dropped_d;
  logic             stuff_err_q, stuff_err_d;
  logic [RUN_W-1:0] run_len_q, run_len_d;
  logic             last_bit_q, last_bit_d;
  logic [FIX_W-1:0] fix_cnt_q, fix_cnt_d;
  logic [2:0]       dyn_cnt_q, dyn_cnt_d;

  logic smp;
  assign smp = bus.sampled_bit;

  always_comb begin
    state_d             = state_q;
    rx_bit_d            = rx_bit_q;
    rx_bit_valid_d      = 1'b0;
    stuff_bit_dropped_d = 1'b0;
    stuff_err_d         = 1'b0;
    run_len_d           = run_len_q;
    last_bit_d          = last_bit_q;
    fix_cnt_d           = fix_cnt_q;
    dyn_cnt_d           = dyn_cnt_q;

    if (bus.initialize) begin
      state_d    = IDLE;
      run_len_d  = '0;
      fix_cnt_d  = '0;
      dyn_cnt_d  = '0;
      last_bit_d = 1'b1;
    end else if (bus.sample_point) begin
      unique case (state_q)
        IDLE: begin
          if (!smp) begin
            state_d        = DYNAMIC;
            rx_bit_d       = 1'b0;
            rx_bit_valid_d = 1'b1;
            run_len_d      = RUN_W'(1);
            last_bit_d     = 1'b0;
          end
        end

        DYNAMIC: begin
          // Fixed stuffing takes over at once: this very sample is the first fixed stuff bit.
          if (bus.fixed_stuff_mode) begin
            if (smp != last_bit_q) begin
              state_d             = FIXED;
              stuff_bit_dropped_d = 1'b1;
              fix_cnt_d           = '0;
              last_bit_d          = smp;
            end else begin
              state_d     = ERROR;
              stuff_err_d = 1'b1;
            end
          end else if (run_len_q == RUN_W'(STUFF_LEN)) begin
            if (smp != last_bit_q) begin
              stuff_bit_dropped_d = 1'b1;
              run_len_d           = RUN_W'(1);
              last_bit_d          = smp;
              dyn_cnt_d           = dyn_cnt_q + 3'd1;
            end else begin
              state_d     = ERROR;
              stuff_err_d = 1'b1;
            end
          end else begin
            rx_bit_d       = smp;
            rx_bit_valid_d = 1'b1;
            run_len_d      = (smp == last_bit_q) ? run_len_q + RUN_W'(1) : RUN_W'(1);
            last_bit_d     = smp;
          end
        end

        FIXED: begin
          if (!bus.fixed_stuff_mode) begin
            state_d        = DYNAMIC;
            rx_bit_d       = smp;
            rx_bit_valid_d = 1'b1;
            run_len_d      = RUN_W'(1);
            last_bit_d     = smp;
          end else if (fix_cnt_q == FIX_W'(FIXED_INTERVAL)) begin
            if (smp != last_bit_q) begin
              stuff_bit_dropped_d = 1'b1;
              fix_cnt_d           = '0;
              last_bit_d          = smp;
            end else begin
              state_d     = ERROR;
              stuff_err_d = 1'b1;
            end
          end else begin
            rx_bit_d       = smp;
            rx_bit_valid_d = 1'b1;
            fix_cnt_d      = fix_cnt_q + FIX_W'(1);
            last_bit_d     = smp;
          end
        end

        ERROR: ;

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q             <= IDLE;
      rx_bit_q            <= 1'b1;
      rx_bit_valid_q      <= 1'b0;
      stuff_bit_dropped_q <= 1'b0;
      stuff_err_q         <= 1'b0;
      run_len_q           <= '0;
      last_bit_q          <= 1'b1;
      fix_cnt_q           <= '0;
      dyn_cnt_q           <= '0;
    end else begin
      state_q             <= state_d;
      rx_bit_q            <= rx_bit_d;
      rx_bit_valid_q      <= rx_bit_valid_d;
      stuff_bit_dropped_q <= stuff_bit_dropped_d;
      stuff_err_q         <= stuff_err_d;
      run_len_q           <= run_len_d;
      last_bit_q          <= last_bit_d;
      fix_cnt_q           <= fix_cnt_d;
      dyn_cnt_q           <= dyn_cnt_d;
    end
  end

  assign bus.rx_bit             = rx_bit_q;
  assign bus.rx_bit_valid       = rx_bit_valid_q;
  assign bus.stuff_bit_dropped  = stuff_bit_dropped_q;
  assign bus.stuff_err          = stuff_err_q;
  assign bus.stuff_count_gray   = dyn_cnt_q ^ (dyn_cnt_q >> 1);
  assign bus.stuff_count_parity = ^bus.stuff_count_gray;

endmodule

// File: tb/tb_can_fd_bit_destuff.sv
// Directed bench for can_fd_bit_destuff: bit sequences with hand-computed strobes
// and stuff counts, checked with immediate assertions.
module tb_can_fd_bit_destuff;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  can_fd_bit_destuff_if bus ();

  can_fd_bit_destuff dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [2:0] gray, input logic par);
    chk({tag, " gray"}, bus.stuff_count_gray, gray);
    chk({tag, " parity"}, {2'b00, bus.stuff_count_parity}, {2'b00, par});
  endtask

  // One sample_point cycle; outputs are checked on the following falling edge.
  // kind: 0 = no strobe, 1 = rx valid (rx_bit = erx), 2 = dropped, 3 = stuff_err
  task automatic send(input string tag, input logic b, input logic fsm, input logic init,
                      input int kind, input logic erx);
    @(negedge clk);
    bus.sample_point     = 1'b1;
    bus.sampled_bit      = b;
    bus.fixed_stuff_mode = fsm;
    bus.initialize       = init;
    @(negedge clk);
    bus.sample_point = 1'b0;
    bus.initialize   = 1'b0;
    chk({tag, " valid"}, {2'b00, bus.rx_bit_valid}, {2'b00, logic'(kind == 1)});
    chk({tag, " drop"},  {2'b00, bus.stuff_bit_dropped}, {2'b00, logic'(kind == 2)});
    chk({tag, " err"},   {2'b00, bus.stuff_err}, {2'b00, logic'(kind == 3)});
    if (kind == 1) chk({tag, " rx_bit"}, {2'b00, bus.rx_bit}, {2'b00, erx});
    $display("txn %-10s bit=%b fsm=%b init=%b -> valid=%b rx=%b drop=%b err=%b gray=%b",
             tag, b, fsm, init, bus.rx_bit_valid, bus.rx_bit, bus.stuff_bit_dropped,
             bus.stuff_err, bus.stuff_count_gray);
  endtask

  task automatic do_init();
    @(negedge clk);
    bus.initialize = 1'b1;
    @(negedge clk);
    bus.initialize = 1'b0;
  endtask

  initial begin
    logic b;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.sample_point     = 1'b0;
    bus.sampled_bit      = 1'b1;
    bus.initialize       = 1'b0;
    bus.fixed_stuff_mode = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst rx_bit", {2'b00, bus.rx_bit}, 3'b001);
    chk("rst valid",  {2'b00, bus.rx_bit_valid}, 3'b000);
    chk("rst drop",   {2'b00, bus.stuff_bit_dropped}, 3'b000);
    chk("rst err",    {2'b00, bus.stuff_err}, 3'b000);
    chk_cnt("rst", 3'b000, 1'b0);
    rst_n = 1'b1;

    // Recessive bit in IDLE is ignored
    send("idle1", 1'b1, 1'b0, 1'b0, 0, 1'b0);

    // 0,0,0,0,0,1,1 : five valids, one drop, one valid '1'
    for (int i = 0; i < 5; i++) send("s1 zero", 1'b0, 1'b0, 1'b0, 1, 1'b0);
    send("s1 stuff", 1'b1, 1'b0, 1'b0, 2, 1'b0);
    send("s1 data1", 1'b1, 1'b0, 1'b0, 1, 1'b1);
    chk_cnt("s1", 3'b001, 1'b1);
    @(negedge clk);
    chk("idle cycle valid", {2'b00, bus.rx_bit_valid}, 3'b000);
    do_init();
    chk_cnt("s1 init", 3'b000, 1'b0);

    // Six zeros: five valids, then stuff error, then silence
    for (int i = 0; i < 5; i++) send("s2 zero", 1'b0, 1'b0, 1'b0, 1, 1'b0);
    send("s2 6th", 1'b0, 1'b0, 1'b0, 3, 1'b0);
    send("s2 err1", 1'b1, 1'b0, 1'b0, 0, 1'b0);
    send("s2 err0", 1'b0, 1'b0, 1'b0, 0, 1'b0);
    do_init();

    // 0,1,1,1,1,1,0(stuff),0,0,0,0 then stuff 1
    send("s3 sof", 1'b0, 1'b0, 1'b0, 1, 1'b0);
    for (int i = 0; i < 5; i++) send("s3 one", 1'b1, 1'b0, 1'b0, 1, 1'b1);
    send("s3 stuff0", 1'b0, 1'b0, 1'b0, 2, 1'b0);
    chk_cnt("s3 a", 3'b001, 1'b1);
    for (int i = 0; i < 4; i++) send("s3 zero", 1'b0, 1'b0, 1'b0, 1, 1'b0);
    send("s3 stuff1", 1'b1, 1'b0, 1'b0, 2, 1'b0);
    chk_cnt("s3 b", 3'b011, 1'b0);
    do_init();

    // Eight dynamic stuff bits: count 3 -> gray 010, count 8 -> wraps to 000
    send("s4 sof", 1'b0, 1'b0, 1'b0, 1, 1'b0);
    for (int i = 0; i < 4; i++) send("s4 zero", 1'b0, 1'b0, 1'b0, 1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      b = (k % 2 == 1) ? 1'b1 : 1'b0;
      send("s4 stuff", b, 1'b0, 1'b0, 2, 1'b0);
      if (k == 3) chk_cnt("s4 three", 3'b010, 1'b1);
      for (int i = 0; i < 4; i++) send("s4 data", b, 1'b0, 1'b0, 1, b);
    end
    chk_cnt("s4 eight", 3'b000, 1'b0);
    do_init();

    // Fixed stuffing: last_bit=1, bits 0,1,0,1,1,0,1,0,0,1 then wrong stuff 1
    send("s5 sof", 1'b0, 1'b0, 1'b0, 1, 1'b0);
    send("s5 one", 1'b1, 1'b0, 1'b0, 1, 1'b1);
    send("s5 fst0", 1'b0, 1'b1, 1'b0, 2, 1'b0);
    send("s5 a", 1'b1, 1'b1, 1'b0, 1, 1'b1);
    send("s5 b", 1'b0, 1'b1, 1'b0, 1, 1'b0);
    send("s5 c", 1'b1, 1'b1, 1'b0, 1, 1'b1);
    send("s5 d", 1'b1, 1'b1, 1'b0, 1, 1'b1);
    send("s5 fst1", 1'b0, 1'b1, 1'b0, 2, 1'b0);
    send("s5 e", 1'b1, 1'b1, 1'b0, 1, 1'b1);
    send("s5 f", 1'b0, 1'b1, 1'b0, 1, 1'b0);
    send("s5 g", 1'b0, 1'b1, 1'b0, 1, 1'b0);
    send("s5 h", 1'b1, 1'b1, 1'b0, 1, 1'b1);
    send("s5 badfs", 1'b1, 1'b1, 1'b0, 3, 1'b0);
    chk_cnt("s5", 3'b000, 1'b0);
    do_init();

    // FIXED -> DYNAMIC: run restarts at 1, next dynamic stuff counted
    send("s6 sof", 1'b0, 1'b0, 1'b0, 1, 1'b0);
    send("s6 one", 1'b1, 1'b0, 1'b0, 1, 1'b1);
    send("s6 fst", 1'b0, 1'b1, 1'b0, 2, 1'b0);
    send("s6 a", 1'b1, 1'b1, 1'b0, 1, 1'b1);
    send("s6 b", 1'b1, 1'b1, 1'b0, 1, 1'b1);
    send("s6 back", 1'b1, 1'b0, 1'b0, 1, 1'b1);
    for (int i = 0; i < 4; i++) send("s6 one", 1'b1, 1'b0, 1'b0, 1, 1'b1);
    send("s6 stuff", 1'b0, 1'b0, 1'b0, 2, 1'b0);
    chk_cnt("s6", 3'b001, 1'b1);
    do_init();

    // initialize together with sample_point mid-frame
    send("s7 sof", 1'b0, 1'b0, 1'b0, 1, 1'b0);
    for (int i = 0; i < 4; i++) send("s7 zero", 1'b0, 1'b0, 1'b0, 1, 1'b0);
    send("s7 stuff", 1'b1, 1'b0, 1'b0, 2, 1'b0);
    chk_cnt("s7 pre", 3'b001, 1'b1);
    send("s7 init", 1'b1, 1'b0, 1'b1, 0, 1'b0);
    chk_cnt("s7 post", 3'b000, 1'b0);
    send("s7 idle1", 1'b1, 1'b0, 1'b0, 0, 1'b0);
    send("s7 sof2", 1'b0, 1'b0, 1'b0, 1, 1'b0);

    // Asynchronous reset while a valid strobe is high
    @(negedge clk);
    bus.sample_point = 1'b1;
    bus.sampled_bit  = 1'b0;
    @(posedge clk);
    #2;
    bus.sample_point = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst valid",  {2'b00, bus.rx_bit_valid}, 3'b000);
    chk("arst rx_bit", {2'b00, bus.rx_bit}, 3'b001);
    chk("arst err",    {2'b00, bus.stuff_err}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    send("s8 idle1", 1'b1, 1'b0, 1'b0, 0, 1'b0);
    send("s8 sof", 1'b0, 1'b0, 1'b0, 1, 1'b0);
    send("s8 one", 1'b1, 1'b0, 1'b0, 1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
